// File: rtl/sgpr_pkg.sv
// Shared types and constants for the shared-GPR recovery block.
package sgpr_pkg;
    typedef enum logic [1:0] {RUN, HALT, RESTORE, RESUME} sgpr_state_e;

    localparam int NUM_REGS          = 32;
    localparam int FIRST_RESTORE_REG = 1;
    localparam int LAST_RESTORE_REG  = 31;
endpackage

// File: rtl/sgpr_recovery_if.sv
// Comparator-side bus into the recovery block and the restore/status bus out of it.
interface sgpr_recovery_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int ERR_CNT_WIDTH = 16
);
    logic                     we_a_i;
    logic                     we_b_i;
    logic [ADDR_WIDTH-1:0]    addr_i;
    logic [DATA_WIDTH-1:0]    data_i;
    logic                     mismatch_i;
    logic                     halt_o;
    logic                     restore_we_o;
    logic [ADDR_WIDTH-1:0]    restore_addr_o;
    logic [DATA_WIDTH-1:0]    restore_data_o;
    logic                     recovering_o;
    logic [ERR_CNT_WIDTH-1:0] err_count_o;

    modport master (
        output we_a_i, we_b_i, addr_i, data_i, mismatch_i,
        input  halt_o, restore_we_o, restore_addr_o, restore_data_o, recovering_o, err_count_o
    );

    modport slave (
        input  we_a_i, we_b_i, addr_i, data_i, mismatch_i,
        output halt_o, restore_we_o, restore_addr_o, restore_data_o, recovering_o, err_count_o
    );
endinterface

// File: rtl/sgpr_golden_rf.sv
// Golden GPR copy: one synchronous write port, one combinational read port, x0 reads zero.
module sgpr_golden_rf
    import sgpr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int ENTRIES = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == '0) ? '0 : mem[raddr];
endmodule

// File: rtl/sgpr_recovery.sv
// Commits agreed GPR writes to the golden copy; on a qualified mismatch halts both cores and replays x1..x31.
module sgpr_recovery
    import sgpr_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int ERR_CNT_WIDTH = 16
) (
    input logic clk_i,
    input logic rst_ni,
    sgpr_recovery_if.slave bus
);
    sgpr_state_e state, state_nxt;
    logic [ADDR_WIDTH-1:0]    idx, idx_nxt;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;
    logic [DATA_WIDTH-1:0]    rf_rdata;
    logic                     qual_err, commit, restoring;

    // Mismatch with no write enable is a don't-care difference, not an error.
    assign qual_err = bus.mismatch_i && (bus.we_a_i || bus.we_b_i);
    assign commit   = (state == RUN) && bus.we_a_i && bus.we_b_i && !bus.mismatch_i;

    sgpr_golden_rf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_golden (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .we    (commit),
        .waddr (bus.addr_i),
        .wdata (bus.data_i),
        .raddr (idx),
        .rdata (rf_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RUN;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            RUN:     if (qual_err) state_nxt = HALT;
            HALT: begin
                state_nxt = RESTORE;
                idx_nxt   = ADDR_WIDTH'(FIRST_RESTORE_REG);
            end
            RESTORE: begin
                idx_nxt = idx + 1'b1;
                if (idx == ADDR_WIDTH'(LAST_RESTORE_REG)) state_nxt = RESUME;
            end
            RESUME:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt <= '0;
        end else if (state == RUN && qual_err && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    // All outputs decode registered state only; no input reaches them combinationally.
    assign restoring           = (state == RESTORE);
    assign bus.halt_o          = (state != RUN);
    assign bus.recovering_o    = (state == HALT);
    assign bus.restore_we_o    = restoring;
    assign bus.restore_addr_o  = restoring ? idx : '0;
    assign bus.restore_data_o  = restoring ? rf_rdata : '0;
    assign bus.err_count_o     = err_cnt;
endmodule
